// File: rtl/i2s_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2s_rx : I2S slave receiver, stereo words resynchronized into clk domain |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module i2s_rx #(
  parameter int DATA_W  = 24,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i2s_bck,
  input  logic              i2s_lrck,
  input  logic              i2s_data,
  output logic [DATA_W-1:0] left_out,
  output logic [DATA_W-1:0] right_out,
  output logic              out_valid,
  output logic              frame_err,
  output logic              locked
);

  localparam int              TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
  localparam logic [6:0]      DW7    = 7'(DATA_W);

  localparam logic [1:0] HUNT  = 2'd0;
  localparam logic [1:0] LEFT  = 2'd1;
  localparam logic [1:0] RIGHT = 2'd2;

  logic              bck_s1, bck_s2, bck_s3;
  logic              lrck_s1, lrck_s2;
  logic              data_s1, data_s2;
  logic              lrck_prev;
  logic [5:0]        cnt;
  logic [DATA_W-1:0] word, word_cur, left_word;
  logic [6:0]        left_n, slot_n;
  logic [TO_W-1:0]   to_cnt;
  logic [1:0]        state, state_nxt;
  logic              bck_rise, chg, chg_rise, chg_fall, timeout;
  logic              latch_left, emit, err, good;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bck_s1  <= 1'b0;
      bck_s2  <= 1'b0;
      bck_s3  <= 1'b0;
      lrck_s1 <= 1'b0;
      lrck_s2 <= 1'b0;
      data_s1 <= 1'b0;
      data_s2 <= 1'b0;
    end else begin
      bck_s1  <= i2s_bck;
      bck_s2  <= bck_s1;
      bck_s3  <= bck_s2;
      lrck_s1 <= i2s_lrck;
      lrck_s2 <= lrck_s1;
      data_s1 <= i2s_data;
      data_s2 <= data_s1;
    end
  end

  assign bck_rise = bck_s2 & ~bck_s3;
  assign chg      = bck_rise & (lrck_s2 != lrck_prev);
  assign chg_rise = chg & lrck_s2;
  assign chg_fall = chg & ~lrck_s2;
  assign timeout  = (to_cnt == TO_MAX);
  assign slot_n   = {1'b0, cnt} + 7'd1;
  assign err      = (left_n < DW7) || (slot_n < DW7) || (left_n != slot_n);

  // Current word with the bit of this bck_rise merged in (MSB first, overflow dropped)
  always_comb begin
    word_cur = word;
    for (int b = 0; b < DATA_W; b++) begin
      if (int'(cnt) == DATA_W - 1 - b) word_cur[b] = data_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = HUNT;
    end else begin
      case (state)
        HUNT:    if (chg_fall) state_nxt = LEFT;
        LEFT:    if (chg_rise) state_nxt = RIGHT;
        RIGHT:   if (chg_fall) state_nxt = LEFT;
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    latch_left = 1'b0;
    emit       = 1'b0;
    if (!timeout) begin
      latch_left = (state == LEFT)  && chg_rise;
      emit       = (state == RIGHT) && chg_fall;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lrck_prev <= 1'b0;
      cnt       <= '0;
      word      <= '0;
      left_word <= '0;
      left_n    <= '0;
      to_cnt    <= '0;
    end else begin
      if (bck_rise) begin
        lrck_prev <= lrck_s2;
        if (chg) begin
          cnt  <= '0;
          word <= '0;
        end else begin
          if (cnt != 6'd63) cnt <= cnt + 6'd1;
          word <= word_cur;
        end
      end
      if (latch_left) begin
        left_word <= word_cur;
        left_n    <= slot_n;
      end
      if (bck_rise)      to_cnt <= '0;
      else if (!timeout) to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_out  <= '0;
      right_out <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      locked    <= 1'b0;
      good      <= 1'b0;
    end else begin
      out_valid <= emit;
      frame_err <= emit & err;
      if (emit) begin
        left_out  <= left_word;
        right_out <= word_cur;
      end
      // good remembers one clean pair; a second consecutive clean pair locks
      if (timeout) begin
        locked <= 1'b0;
        good   <= 1'b0;
      end else if (emit) begin
        if (err) begin
          locked <= 1'b0;
          good   <= 1'b0;
        end else begin
          if (good) locked <= 1'b1;
          good <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2s_rx : scoreboard bench driving I2S frames into i2s_rx              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_i2s_rx;

  localparam int HALF = 170;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bck = 1'b0;
  logic        lrck = 1'b0;
  logic        data = 1'b0;
  logic [23:0] left_out, right_out;
  logic        out_valid, frame_err, locked;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        err;
    logic        lock;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          clean_run = 0;
  logic [23:0] last_l = '0;
  logic [23:0] last_r = '0;

  i2s_rx #(.DATA_W(24), .TIMEOUT(255)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i2s_bck   (bck),
    .i2s_lrck  (lrck),
    .i2s_data  (data),
    .left_out  (left_out),
    .right_out (right_out),
    .out_valid (out_valid),
    .frame_err (frame_err),
    .locked    (locked)
  );

  always #21 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_word(input logic [31:0] val, input int n, input int pw);
    logic [23:0] w;
    w = '0;
    for (int i = 0; i < n; i++)
      if (i < 24 && i < pw) w[23-i] = val[pw-1-i];
    return w;
  endfunction

  task automatic bit_out(input logic lr, input logic d);
    bck  = 1'b0;
    lrck = lr;
    data = d;
    #HALF;
    bck = 1'b1;
    #HALF;
  endtask

  // Last bit of a slot carries the opposite LRCK level (one-bit delay)
  task automatic send_slot(input logic [31:0] val, input int n, input int pw, input logic lr);
    for (int i = 0; i < n; i++)
      bit_out((i == n - 1) ? ~lr : lr, (i < pw) ? val[pw-1-i] : 1'b0);
  endtask

  task automatic prelude();
    bit_out(1'b1, 1'b0);
    bit_out(1'b1, 1'b0);
    bit_out(1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                            input int nl, input int nr, input int pw);
    exp_t e;
    e.l   = exp_word(l, nl, pw);
    e.r   = exp_word(r, nr, pw);
    e.err = (nl < 24) || (nr < 24) || (nl != nr);
    if (e.err) clean_run = 0;
    else       clean_run++;
    e.lock = (clean_run >= 2);
    sb.push_back(e);
    last_l = e.l;
    last_r = e.r;
    send_slot(l, nl, pw, 1'b0);
    send_slot(r, nr, pw, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check_val("spurious_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("left_out",  {8'd0, left_out},  {8'd0, e.l});
        check_val("right_out", {8'd0, right_out}, {8'd0, e.r});
        check_val("frame_err", {31'd0, frame_err}, {31'd0, e.err});
        check_val("locked",    {31'd0, locked},    {31'd0, e.lock});
      end
    end
    if (rst_n && frame_err && !out_valid)
      check_val("err_without_valid", {31'd0, frame_err}, 32'd0);
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_left",   {8'd0, left_out},  32'd0);
    check_val("rst_right",  {8'd0, right_out}, 32'd0);
    check_val("rst_valid",  {31'd0, out_valid}, 32'd0);
    check_val("rst_err",    {31'd0, frame_err}, 32'd0);
    check_val("rst_locked", {31'd0, locked},    32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 64-bit frames, 24-bit payload
    prelude();
    for (int k = 0; k < 4; k++) send_frame(32'hA5A5A5, 32'h5A5A5A, 32, 32, 24);
    // 48-bit frames
    for (int k = 0; k < 2; k++) send_frame(32'h800001, 32'h000001, 24, 24, 24);

    // BCK stall: lock survives below TIMEOUT, drops beyond it, outputs hold
    bck = 1'b0;
    repeat (200) @(posedge clk);
    #1 check_val("stall_locked_200", {31'd0, locked}, 32'd1);
    repeat (100) @(posedge clk);
    #1 check_val("stall_locked_300", {31'd0, locked}, 32'd0);
    check_val("stall_left_hold",  {8'd0, left_out},  {8'd0, last_l});
    check_val("stall_right_hold", {8'd0, right_out}, {8'd0, last_r});
    clean_run = 0;
    prelude();
    for (int k = 0; k < 2; k++) send_frame(32'h123456, 32'h654321, 32, 32, 24);

    // Mismatched slot lengths
    send_frame(32'h0F0F0F, 32'hF0F0F0, 32, 31, 24);
    // Short 16-bit slots
    for (int k = 0; k < 2; k++) send_frame(32'hFFFF, 32'h1234, 16, 16, 16);
    for (int k = 0; k < 2; k++) send_frame(32'h000000, 32'hFFFFFF, 32, 32, 24);

    // Reset in the middle of a right slot
    send_slot(32'hC3C3C3, 32, 24, 1'b0);
    for (int i = 0; i < 10; i++) bit_out(1'b1, 1'b1);
    bck = 1'b0;
    repeat (2) @(posedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("mid_rst_left",   {8'd0, left_out},  32'd0);
    check_val("mid_rst_right",  {8'd0, right_out}, 32'd0);
    check_val("mid_rst_valid",  {31'd0, out_valid}, 32'd0);
    check_val("mid_rst_err",    {31'd0, frame_err}, 32'd0);
    check_val("mid_rst_locked", {31'd0, locked},    32'd0);
    rst_n = 1'b1;
    clean_run = 0;
    for (int i = 10; i < 32; i++) bit_out((i == 31) ? 1'b0 : 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1 check_val("post_rst_left",  {8'd0, left_out},  32'd0);
    check_val("post_rst_right", {8'd0, right_out}, 32'd0);
    for (int k = 0; k < 2; k++) send_frame(32'h3C3C3C, 32'hABCDEF, 32, 32, 24);

    bck = 1'b0;
    repeat (10) @(posedge clk);
    check_val("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter DATA_W, default 24, sets the stored bits per channel word.
REQ-002 Parameter TIMEOUT, default 255, sets the clk cycles without a BCK rising edge before the block loses lock.
REQ-003 clk  input  1  logic clock (24 MHz nominal).
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i2s_bck  input  1  MCU I2S bit clock, asynchronous to clk.
REQ-006 i2s_lrck  input  1  MCU I2S word select: 0 = left, 1 = right; asynchronous.
REQ-007 i2s_data  input  1  MCU I2S serial data, MSB first; asynchronous.
REQ-008 left_out  output  DATA_W  last completed left word.
REQ-009 right_out  output  DATA_W  last completed right word.
REQ-010 out_valid  output  1  one-clk pulse: new left/right pair on the outputs.
REQ-011 frame_err  output  1  one-clk pulse, coincident with out_valid, marking a malformed frame.
REQ-012 locked  output  1  level: stream judged stable.

Function
REQ-013 i2s_bck, i2s_lrck and i2s_data SHALL each pass through a 2-FF synchronizer; a third BCK register SHALL form bck_rise (stage2=1, stage3=0).
REQ-014 All protocol decisions SHALL occur only in cycles with bck_rise; sync-stage-2 LRCK and DATA are sampled in that cycle.
REQ-015 A register lrck_prev SHALL hold the LRCK sampled at the previous bck_rise; a "change rise" is a bck_rise where sampled LRCK differs from lrck_prev.
REQ-016 I2S 1-bit delay: the data bit at a change rise is the last bit of the ending slot; the next bck_rise carries the MSB of the new slot.
REQ-017 A per-slot bit counter cnt (6 bits, saturating at 63) SHALL clear at each change rise and increment on every other bck_rise.
REQ-018 The bit at slot index i (0 = MSB) SHALL be written to word bit DATA_W-1-i when i < DATA_W; bits with i >= DATA_W are discarded.
REQ-019 Word bits not written in a short slot SHALL read 0; the word register clears at slot start.
REQ-020 Slot length n = number of bits, including the change-rise bit.
REQ-021 States: HUNT, LEFT, RIGHT.
REQ-022 HUNT->LEFT on a change rise with LRCK 1->0; the 0->1 change is ignored in HUNT.
REQ-023 LEFT->RIGHT on a 0->1 change rise; the left word, including that final bit, is latched internally.
REQ-024 RIGHT->LEFT on a 1->0 change rise; left_out and right_out (right word including final bit) update and out_valid pulses.
REQ-025 No output SHALL be emitted for the slot in progress when HUNT is left.
REQ-026 frame_err SHALL pulse with out_valid when left n < DATA_W, right n < DATA_W, or left n != right n.
REQ-027 Latency: outputs update on the 3rd clk rising edge after the i2s_bck pin rising edge of the completing change rise.
REQ-028 A timeout counter SHALL clear on bck_rise and otherwise increment, saturating.
REQ-029 When the timeout counter reaches TIMEOUT, the FSM SHALL go to HUNT and locked SHALL clear; any partial frame is discarded and left_out/right_out hold.
REQ-030 locked SHALL set on the second consecutive out_valid without frame_err.
REQ-031 locked SHALL clear on any frame_err pulse or on timeout.
REQ-032 Input constraint: BCK high and low phases SHALL each be at least 2 clk periods.

Reset
REQ-033 While rst_n=0: left_out=0, right_out=0, out_valid=0, frame_err=0, locked=0; state HUNT; synchronizers, lrck_prev, cnt, word registers and timeout counter are 0.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame with no pulse on out_valid.
REQ-035 After release, the first out_valid requires a complete LEFT and RIGHT slot.

Verification
REQ-036 DATA_W=24, 64-bit frames (BCK=3.072 MHz), L=0xA5A5A5, R=0x5A5A5A, 4 frames -> first pair after one full frame from HUNT; values exact; frame_err=0; locked=1 after the 2nd pulse.
REQ-037 48-bit frames with 24-bit payload L=0x800001, R=0x000001 -> exact values, no frame_err.
REQ-038 32-bit frames, 16 bits/slot, L=0xFFFF, R=0x1234 -> left_out=0xFFFF00, right_out=0x123400, frame_err pulses, locked=0.
REQ-039 Stop BCK for 300 clk after lock -> locked falls at TIMEOUT, outputs hold; restart -> re-lock after 2 clean frames.
REQ-040 Assert rst_n=0 for 3 clk mid right slot -> all outputs 0, no pulse; next out_valid only after a full subsequent frame.
REQ-041 Left slot 32 bits, right slot 31 bits -> frame_err pulses with out_valid; locked clears.
